// File: rtl/flicky_video_pkg.sv
// Shared timing defaults, sync-flag/colour types and the POUT colour expansion
// used by the Flicky video output path.
package flicky_video_pkg;

  localparam int DEF_CLK_DIV    = 8;
  localparam int DEF_H_TOTAL    = 384;
  localparam int DEF_H_ACTIVE   = 256;
  localparam int DEF_HS_START   = 288;
  localparam int DEF_HS_END     = 320;
  localparam int DEF_V_TOTAL    = 264;
  localparam int DEF_V_ACTIVE   = 224;
  localparam int DEF_VS_START   = 240;
  localparam int DEF_VS_END     = 243;
  localparam int DEF_PIPE_DELAY = 2;

  // POUT packs {B[1:0],G[2:0],R[2:0]}
  localparam int POUT_R_LSB = 0;
  localparam int POUT_G_LSB = 3;
  localparam int POUT_B_LSB = 6;

  typedef struct packed {
    logic hb;
    logic vb;
    logic hs;
    logic vs;
  } syncFlags_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam syncFlags_t FLAGS_IDLE = '{hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0};

  // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
  function automatic rgb_t expandPixel(input logic [7:0] pix);
    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;
    rgb_t       c;
    r3  = pix[POUT_R_LSB +: 3];
    g3  = pix[POUT_G_LSB +: 3];
    b2  = pix[POUT_B_LSB +: 2];
    c.r = {r3, r3, r3[2:1]};
    c.g = {g3, g3, g3[2:1]};
    c.b = {b2, b2, b2, b2};
    return c;
  endfunction

endpackage

// File: rtl/flicky_sync_delay.sv
// Pixel-enable-gated shift register that lines the raw blank/sync flags up
// with the pixel the core returns STAGES pixel periods later.
module flicky_sync_delay
  import flicky_video_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       clk48M,
  input  logic       reset,
  input  logic       ce,
  input  syncFlags_t din,
  output syncFlags_t dout
);

  generate
    if (STAGES == 0) begin : gNoDelay
      logic unusedInputs;
      assign unusedInputs = clk48M ^ reset ^ ce;
      assign dout = din;
    end else begin : gDelay
      syncFlags_t stage [STAGES];

      always_ff @(posedge clk48M) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) begin
            stage[i] <= FLAGS_IDLE;
          end
        end else if (ce) begin
          stage[0] <= din;
          for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/flicky_video_timing.sv
// Raster timing for the Flicky core: pixel enable and PH/PV out, POUT back in,
// blank/sync-aligned 8:8:8 RGB towards the VGA encoder.
module flicky_video_timing
  import flicky_video_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int HS_START   = DEF_HS_START,
  parameter int HS_END     = DEF_HS_END,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int VS_START   = DEF_VS_START,
  parameter int VS_END     = DEF_VS_END,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic       clk48M,
  input  logic       reset,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       CE_PIX,
  input  logic [7:0] POUT,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HS,
  output logic       VS
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  syncFlags_t       rawFlags;
  syncFlags_t       delayedFlags;
  rgb_t             pixColour;

  assign CE_PIX = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk48M) begin
    if (reset) begin
      div <= '0;
    end else if (CE_PIX) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Line and frame wrap both happen on the same pixel enable as the last pixel.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      PH <= '0;
      PV <= '0;
    end else if (CE_PIX) begin
      if (PH == 9'(H_TOTAL - 1)) begin
        PH <= '0;
        PV <= (PV == 9'(V_TOTAL - 1)) ? '0 : PV + 9'd1;
      end else begin
        PH <= PH + 9'd1;
      end
    end
  end

  always_comb begin
    rawFlags    = FLAGS_IDLE;
    rawFlags.hb = (PH >= 9'(H_ACTIVE));
    rawFlags.vb = (PV >= 9'(V_ACTIVE));
    rawFlags.hs = (PH >= 9'(HS_START)) && (PH < 9'(HS_END));
    rawFlags.vs = (PV >= 9'(VS_START)) && (PV < 9'(VS_END));
  end

  flicky_sync_delay #(
    .STAGES(PIPE_DELAY)
  ) syncDelay (
    .clk48M(clk48M),
    .reset (reset),
    .ce    (CE_PIX),
    .din   (rawFlags),
    .dout  (delayedFlags)
  );

  assign pixColour = expandPixel(POUT);

  // POUT arriving now belongs to the coordinate whose flags leave the delay line now.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      HBLANK <= 1'b1;
      VBLANK <= 1'b1;
      HS     <= 1'b0;
      VS     <= 1'b0;
    end else if (CE_PIX) begin
      HBLANK <= delayedFlags.hb;
      VBLANK <= delayedFlags.vb;
      HS     <= delayedFlags.hs;
      VS     <= delayedFlags.vs;
      if (delayedFlags.hb || delayedFlags.vb) begin
        R <= '0;
        G <= '0;
        B <= '0;
      end else begin
        R <= pixColour.r;
        G <= pixColour.g;
        B <= pixColour.b;
      end
    end
  end

endmodule

// File: tb/tb_flicky_video_timing.sv
// Bench for flicky_video_timing: scoreboarded default build, a shrunk-timing
// build for whole-frame behaviour, and a PIPE_DELAY=0 build.
module tb_flicky_video_timing;

  localparam int H_TOTAL  = 384;
  localparam int H_ACTIVE = 256;
  localparam int HS_START = 288;
  localparam int HS_END   = 320;
  localparam int V_TOTAL  = 264;
  localparam int V_ACTIVE = 224;
  localparam int VS_START = 240;
  localparam int VS_END   = 243;

  localparam int S_DIV = 4;
  localparam int S_HT  = 20;
  localparam int S_HA  = 12;
  localparam int S_HSS = 14;
  localparam int S_HSE = 16;
  localparam int S_VT  = 16;
  localparam int S_VA  = 10;
  localparam int S_VSS = 11;
  localparam int S_VSE = 14;

  typedef struct packed {
    logic [7:0] pix;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } sbEntry_t;

  logic       clk;
  logic       reset0, reset1, reset2;
  logic [7:0] POUT0, POUT1, POUT2;
  logic [8:0] ph0, pv0, ph1, pv1, ph2, pv2;
  logic       ce0, ce1, ce2;
  logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic       hblank0, vblank0, hs0, vs0;
  logic       hblank1, vblank1, hs1, vs1;
  logic       hblank2, vblank2, hs2, vs2;

  int         checks = 0;
  int         errors = 0;
  int         cyc;
  int         bx0, by0, sx, sy, nx, ny;
  int         vsHigh, vsRise, vbHigh, hbHigh, hsHigh, whiteHigh;
  logic       prevVs;
  sbEntry_t   q0[$];
  sbEntry_t   prevNd;

  flicky_video_timing dut0 (
    .clk48M(clk), .reset(reset0), .PH(ph0), .PV(pv0), .CE_PIX(ce0), .POUT(POUT0),
    .R(r0), .G(g0), .B(b0), .HBLANK(hblank0), .VBLANK(vblank0), .HS(hs0), .VS(vs0)
  );

  flicky_video_timing #(
    .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_ACTIVE(S_HA), .HS_START(S_HSS), .HS_END(S_HSE),
    .V_TOTAL(S_VT), .V_ACTIVE(S_VA), .VS_START(S_VSS), .VS_END(S_VSE), .PIPE_DELAY(2)
  ) dut1 (
    .clk48M(clk), .reset(reset1), .PH(ph1), .PV(pv1), .CE_PIX(ce1), .POUT(POUT1),
    .R(r1), .G(g1), .B(b1), .HBLANK(hblank1), .VBLANK(vblank1), .HS(hs1), .VS(vs1)
  );

  flicky_video_timing #(
    .PIPE_DELAY(0)
  ) dut2 (
    .clk48M(clk), .reset(reset2), .PH(ph2), .PV(pv2), .CE_PIX(ce2), .POUT(POUT2),
    .R(r2), .G(g2), .B(b2), .HBLANK(hblank2), .VBLANK(vblank2), .HS(hs2), .VS(vs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] modelColour(input logic [7:0] pix);
    int rr, gg, bb;
    rr = 36 * int'(pix[2:0]) + int'(pix[2:0]) / 2;
    gg = 36 * int'(pix[5:3]) + int'(pix[5:3]) / 2;
    bb = 85 * int'(pix[7:6]);
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  function automatic logic [3:0] modelFlags(input int x, input int y, input int ha,
                                            input int hss, input int hse, input int va,
                                            input int vss, input int vse);
    logic [3:0] f;
    f[3] = (x >= ha);
    f[2] = (y >= va);
    f[1] = (x >= hss) && (x < hse);
    f[0] = (y >= vss) && (y < vse);
    return f;
  endfunction

  function automatic sbEntry_t makeEntry(input logic [7:0] pix, input logic [3:0] f);
    sbEntry_t e;
    e.pix = pix;
    e.hb  = f[3];
    e.vb  = f[2];
    e.hs  = f[1];
    e.vs  = f[0];
    if (f[3] || f[2]) {e.r, e.g, e.b} = '0;
    else {e.r, e.g, e.b} = modelColour(pix);
    return e;
  endfunction

  function automatic logic [27:0] entryVideo(input sbEntry_t e);
    return {e.hb, e.vb, e.hs, e.vs, e.r, e.g, e.b};
  endfunction

  task automatic waitCe(input int which, input int limit, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      case (which)
        0:       seen = ce0;
        1:       seen = ce1;
        default: seen = ce2;
      endcase
    end
    if (!seen) checkOutput("ce_timeout", 64'(seen), 64'd1);
  endtask

  // After reset the first three outputs come from the cleared delay line.
  task automatic resetMainModel();
    bx0 = 0;
    by0 = 0;
    q0.delete();
    repeat (3) q0.push_back(makeEntry(8'h00, 4'b1100));
  endtask

  task automatic applyStimulus(output int cycles);
    logic [7:0] pix;
    sbEntry_t   old;
    waitCe(0, 3 * 8, cycles);
    checkOutput("main_ph_pv", 64'({ph0, pv0}), 64'({9'(bx0), 9'(by0)}));
    if (bx0 == 5) pix = 8'hFF;
    else if (bx0 == 6) pix = 8'h07;
    else if (bx0 == 7) pix = 8'h00;
    else pix = 8'($urandom);
    q0.push_back(makeEntry(pix, modelFlags(bx0, by0, H_ACTIVE, HS_START, HS_END,
                                           V_ACTIVE, VS_START, VS_END)));
    POUT0 = q0[q0.size() - 3].pix;
    old = q0.pop_front();
    checkOutput("main_video", 64'({hblank0, vblank0, hs0, vs0, r0, g0, b0}),
                64'(entryVideo(old)));
    bx0++;
    if (bx0 == H_TOTAL) begin
      bx0 = 0;
      by0 = (by0 == V_TOTAL - 1) ? 0 : by0 + 1;
    end
  endtask

  initial begin
    reset0 = 1'b1;
    reset1 = 1'b1;
    reset2 = 1'b1;
    POUT0  = 8'h00;
    POUT1  = 8'hFF;
    POUT2  = 8'h07;
    repeat (3) @(negedge clk);
    $display("[TB] checking reset state");
    checkOutput("reset_ph_pv", 64'({ph0, pv0}), 64'd0);
    checkOutput("reset_ce", 64'(ce0), 64'd0);
    checkOutput("reset_rgb", 64'({r0, g0, b0}), 64'd0);
    checkOutput("reset_blank", 64'({hblank0, vblank0}), 64'd3);
    checkOutput("reset_sync", 64'({hs0, vs0}), 64'd0);

    resetMainModel();
    reset0 = 1'b0;
    applyStimulus(cyc);
    checkOutput("main_first_ce", 64'(cyc), 64'd7);
    applyStimulus(cyc);
    checkOutput("main_ce_period", 64'(cyc), 64'd8);
    while (!(bx0 == 200 && by0 == 2)) applyStimulus(cyc);

    $display("[TB] mid-frame reset");
    @(negedge clk);
    checkOutput("mid_pre_reset", 64'({ph0, pv0}), 64'({9'd200, 9'd2}));
    reset0 = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_ph_pv", 64'({ph0, pv0}), 64'd0);
    checkOutput("mid_reset_blank", 64'({hblank0, vblank0, hs0, vs0}), 64'hC);
    reset0 = 1'b0;
    resetMainModel();
    applyStimulus(cyc);
    checkOutput("mid_first_ce", 64'(cyc), 64'd7);
    repeat (12) applyStimulus(cyc);

    $display("[TB] shrunk-timing frames");
    sx = 0;
    sy = 0;
    vsHigh = 0; vsRise = 0; vbHigh = 0; hbHigh = 0; hsHigh = 0; whiteHigh = 0;
    prevVs = 1'b0;
    reset1 = 1'b0;
    for (int n = 0; n < 2 * S_HT * S_VT + 4; n++) begin
      waitCe(1, 3 * S_DIV, cyc);
      if (n == 0) checkOutput("small_first_ce", 64'(cyc), 64'(S_DIV - 1));
      checkOutput("small_ph_pv", 64'({ph1, pv1}), 64'({9'(sx), 9'(sy)}));
      if (n >= 100 && n < 100 + S_HT * S_VT) begin
        if (vs1) vsHigh++;
        if (vs1 && !prevVs) vsRise++;
        if (vblank1) vbHigh++;
        if (hblank1) hbHigh++;
        if (hs1) hsHigh++;
        if ({r1, g1, b1} == 24'hFFFFFF) whiteHigh++;
      end
      prevVs = vs1;
      sx++;
      if (sx == S_HT) begin
        sx = 0;
        sy = (sy == S_VT - 1) ? 0 : sy + 1;
      end
    end
    checkOutput("small_vs_pixels", 64'(vsHigh), 64'(3 * S_HT));
    checkOutput("small_vs_pulses", 64'(vsRise), 64'd1);
    checkOutput("small_vblank_pixels", 64'(vbHigh), 64'((S_VT - S_VA) * S_HT));
    checkOutput("small_hblank_pixels", 64'(hbHigh), 64'((S_HT - S_HA) * S_VT));
    checkOutput("small_hs_pixels", 64'(hsHigh), 64'((S_HSE - S_HSS) * S_VT));
    checkOutput("small_white_pixels", 64'(whiteHigh), 64'(S_HA * S_VA));

    $display("[TB] zero pipe delay build");
    nx = 0;
    ny = 0;
    prevNd = makeEntry(8'h00, 4'b1100);
    reset2 = 1'b0;
    for (int n = 0; n < 300; n++) begin
      waitCe(2, 3 * 8, cyc);
      checkOutput("nodelay_ph_pv", 64'({ph2, pv2}), 64'({9'(nx), 9'(ny)}));
      checkOutput("nodelay_video", 64'({hblank2, vblank2, hs2, vs2, r2, g2, b2}),
                  64'(entryVideo(prevNd)));
      if (nx == 256) checkOutput("nodelay_hblank_at_256", 64'(hblank2), 64'd0);
      if (nx == 257) checkOutput("nodelay_hblank_rise", 64'(hblank2), 64'd1);
      prevNd = makeEntry(POUT2, modelFlags(nx, ny, H_ACTIVE, HS_START, HS_END,
                                           V_ACTIVE, VS_START, VS_END));
      nx++;
      if (nx == H_TOTAL) begin
        nx = 0;
        ny++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
